// File: rtl/mux_pipe.sv
// mux_pipe: two-stage pipelined NUM_IN-to-1 select tree with valid/ready handshake
//   clock, reset_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready       request handshake; in_sel/in_data sampled on accept
//   in_sel                  input index, >= NUM_IN flags an error result
//   in_data                 flattened inputs, input k at [k*WIDTH +: WIDTH]
//   out_valid/out_ready     result handshake
//   out_data, out_sel_err   selected input (0 on error) and out-of-range flag
//   err_count               saturating out-of-range accept counter, only with MUX_PIPE_ERR_COUNT_EN
module mux_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 32,
    parameter int GROUP  = 8,
    localparam int SEL_W = $clog2(NUM_IN)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_sel_err
`ifdef MUX_PIPE_ERR_COUNT_EN
    ,
    output logic [15:0]             err_count
`endif
);
    localparam int NG = (NUM_IN + GROUP - 1) / GROUP;
    localparam int GB = $clog2(GROUP);
    localparam int HW = (SEL_W > GB) ? SEL_W - GB : 1;

    logic [NG*GROUP*WIDTH-1:0] pad;
    logic [NG-1:0][WIDTH-1:0]  part, s1_part;
    logic [GB-1:0]             lo;
    logic [HW-1:0]             hi, s1_hi;
    logic [WIDTH-1:0]          pick;
    logic                      err, s1_err, s1_valid, adv, acc;

    assign lo = in_sel[GB-1:0];
    assign err = 32'(in_sel) >= NUM_IN;

    // with a single group there are no upper select bits to carry
    if (SEL_W > GB) begin : g_hi
        assign hi = in_sel[SEL_W-1:GB];
    end else begin : g_nohi
        assign hi = '0;
    end

    // zero-padding the last group makes slots past NUM_IN read 0
    always_comb begin
        pad = '0;
        pad[NUM_IN*WIDTH-1:0] = in_data;
    end

    always_comb begin
        part = '0;
        for (int g = 0; g < NG; g++)
            for (int j = 0; j < GROUP; j++)
                if (lo == GB'(j)) part[g] = pad[(g*GROUP+j)*WIDTH +: WIDTH];
    end

    always_comb begin
        pick = '0;
        for (int g = 0; g < NG; g++)
            if (s1_hi == HW'(g)) pick = s1_part[g];
    end

    assign adv = !out_valid || out_ready;
    assign in_ready = !s1_valid || adv;
    assign acc = in_valid && in_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_part  <= '0;
            s1_hi    <= '0;
            s1_err   <= 1'b0;
        end else if (acc) begin
            s1_valid <= 1'b1;
            s1_part  <= part;
            s1_hi    <= hi;
            s1_err   <= err;
        end else if (adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_sel_err <= 1'b0;
        end else if (adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data    <= s1_err ? '0 : pick;
                out_sel_err <= s1_err;
            end
        end
    end

`ifdef MUX_PIPE_ERR_COUNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            err_count <= '0;
        else if (acc && err && err_count != 16'hFFFF)
            err_count <= err_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_mux_pipe.sv
// tb_mux_pipe: table-driven and model-checked bench for mux_pipe (default and 20x12 instances)
module tb_mux_pipe;
    logic clock, reset_n, in_valid, out_ready;
    logic [4:0] in_sel;
    logic [32*32-1:0] a_data;
    logic [20*12-1:0] b_data;
    logic a_in_ready, b_in_ready, a_out_valid, b_out_valid, a_err, b_err;
    logic [31:0] a_out;
    logic [11:0] b_out;
`ifdef MUX_PIPE_ERR_COUNT_EN
    logic [15:0] a_ec, b_ec;
`endif

    int n_chk = 0, n_fail = 0, cyc = 0, n_out = 0;
    logic [15:0] ec = 16'h0;

    typedef struct { int sel; int t; } item_t;
    item_t q[$];

    typedef struct {
        logic v; logic [4:0] sel; logic ordy;
        logic eov; logic [31:0] ea; logic [11:0] eb; logic ee;
    } row_t;
    row_t tbl[9];

    mux_pipe u_a (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_sel(in_sel), .in_data(a_data), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_out), .out_sel_err(a_err)
`ifdef MUX_PIPE_ERR_COUNT_EN
        , .err_count(a_ec)
`endif
    );

    mux_pipe #(.WIDTH(12), .NUM_IN(20), .GROUP(8)) u_b (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_sel(in_sel), .in_data(b_data), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_out), .out_sel_err(b_err)
`ifdef MUX_PIPE_ERR_COUNT_EN
        , .err_count(b_ec)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    function automatic logic [31:0] exp_a(input int s);
        return 32'hA000_0000 + 32'(s);
    endfunction

    function automatic logic [11:0] exp_b(input int s);
        return (s < 20) ? 12'(12'hA00 + s) : 12'h000;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // called at posedge+1 with inputs already driven; checks against the queue model, then clocks
    task automatic tick();
        logic er, eov, acc, cons;
        int occ;
        #1;
        occ = q.size();
        er = (occ < 2) || out_ready;
        eov = (occ > 0) && (q[0].t < cyc);
        chk("a_in_ready", 64'(a_in_ready), 64'(er));
        chk("b_in_ready", 64'(b_in_ready), 64'(er));
        chk("a_out_valid", 64'(a_out_valid), 64'(eov));
        chk("b_out_valid", 64'(b_out_valid), 64'(eov));
        if (eov) begin
            chk("a_out_data", 64'(a_out), 64'(exp_a(q[0].sel)));
            chk("b_out_data", 64'(b_out), 64'(exp_b(q[0].sel)));
            chk("a_sel_err", 64'(a_err), 64'(0));
            chk("b_sel_err", 64'(b_err), 64'(q[0].sel >= 20));
        end
        acc = in_valid && er;
        cons = eov && out_ready;
        @(posedge clock);
        #1;
        cyc++;
        if (cons) begin
            void'(q.pop_front());
            n_out++;
        end
        if (acc) begin
            q.push_back('{int'(in_sel), cyc});
            if (in_sel >= 5'd20 && ec != 16'hFFFF) ec++;
        end
    endtask

    initial begin
        int base;
        for (int k = 0; k < 32; k++) a_data[k*32 +: 32] = 32'hA000_0000 + 32'(k);
        for (int k = 0; k < 20; k++) b_data[k*12 +: 12] = 12'(12'hA00 + k);
        tbl[0] = '{1'b1, 5'd0,  1'b1, 1'b0, 32'h0,         12'h000, 1'b0};
        tbl[1] = '{1'b1, 5'd7,  1'b1, 1'b0, 32'h0,         12'h000, 1'b0};
        tbl[2] = '{1'b1, 5'd8,  1'b1, 1'b1, 32'hA000_0000, 12'hA00, 1'b0};
        tbl[3] = '{1'b1, 5'd31, 1'b1, 1'b1, 32'hA000_0007, 12'hA07, 1'b0};
        tbl[4] = '{1'b1, 5'd19, 1'b1, 1'b1, 32'hA000_0008, 12'hA08, 1'b0};
        tbl[5] = '{1'b1, 5'd20, 1'b1, 1'b1, 32'hA000_001F, 12'h000, 1'b1};
        tbl[6] = '{1'b0, 5'd0,  1'b1, 1'b1, 32'hA000_0013, 12'hA13, 1'b0};
        tbl[7] = '{1'b0, 5'd0,  1'b1, 1'b1, 32'hA000_0014, 12'h000, 1'b1};
        tbl[8] = '{1'b0, 5'd0,  1'b1, 1'b0, 32'h0,         12'h000, 1'b0};

        reset_n = 1'b1; in_valid = 1'b0; in_sel = 5'd0; out_ready = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_a_out_valid", 64'(a_out_valid), 64'(0));
        chk("rst_b_out_valid", 64'(b_out_valid), 64'(0));
        chk("rst_a_out_data", 64'(a_out), 64'(0));
        chk("rst_b_sel_err", 64'(b_err), 64'(0));
        chk("rst_a_in_ready", 64'(a_in_ready), 64'(1));
        chk("rst_b_in_ready", 64'(b_in_ready), 64'(1));
`ifdef MUX_PIPE_ERR_COUNT_EN
        chk("rst_b_err_count", 64'(b_ec), 64'(0));
`endif
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;

        // full-throughput stream with hand-computed results
        for (int i = 0; i < 9; i++) begin
            in_valid = tbl[i].v; in_sel = tbl[i].sel; out_ready = tbl[i].ordy;
            #1;
            chk("tbl_a_in_ready", 64'(a_in_ready), 64'(1));
            chk("tbl_b_in_ready", 64'(b_in_ready), 64'(1));
            chk("tbl_a_out_valid", 64'(a_out_valid), 64'(tbl[i].eov));
            chk("tbl_b_out_valid", 64'(b_out_valid), 64'(tbl[i].eov));
            if (tbl[i].eov) begin
                chk("tbl_a_out_data", 64'(a_out), 64'(tbl[i].ea));
                chk("tbl_b_out_data", 64'(b_out), 64'(tbl[i].eb));
                chk("tbl_a_sel_err", 64'(a_err), 64'(0));
                chk("tbl_b_sel_err", 64'(b_err), 64'(tbl[i].ee));
            end
            @(posedge clock);
            #1;
        end
`ifdef MUX_PIPE_ERR_COUNT_EN
        chk("tbl_b_err_count", 64'(b_ec), 64'(2));
        chk("tbl_a_err_count", 64'(a_ec), 64'(0));
        ec = 16'd2;
`endif

        // backpressure: stall the output while three requests arrive
        base = n_out;
        in_valid = 1'b1; in_sel = 5'd3; out_ready = 1'b1; tick();
        in_valid = 1'b0; tick();
        in_valid = 1'b1; in_sel = 5'd9; tick();
        out_ready = 1'b0; in_sel = 5'd20; tick();
        in_sel = 5'd6;
        #1;
        chk("bp_in_ready_low", 64'(b_in_ready), 64'(0));
        chk("bp_stall_data", 64'(a_out), 64'(32'hA000_0009));
        #1;
        @(posedge clock);
        #1;
        chk("bp_stall_hold", 64'(b_out), 64'(12'hA09));
        chk("bp_stall_valid", 64'(b_out_valid), 64'(1));
        tick(); tick();
        out_ready = 1'b1; tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("bp_results", 64'(n_out - base), 64'(4));
        chk("bp_drained", 64'(q.size()), 64'(0));

        // reset with two requests in flight
        in_valid = 1'b1; in_sel = 5'd5; tick();
        in_sel = 5'd21; tick();
        in_valid = 1'b0; out_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_a_out_valid", 64'(a_out_valid), 64'(0));
        chk("mid_rst_b_out_valid", 64'(b_out_valid), 64'(0));
        chk("mid_rst_a_out_data", 64'(a_out), 64'(0));
        chk("mid_rst_b_out_data", 64'(b_out), 64'(0));
        chk("mid_rst_b_sel_err", 64'(b_err), 64'(0));
`ifdef MUX_PIPE_ERR_COUNT_EN
        chk("mid_rst_b_err_count", 64'(b_ec), 64'(0));
`endif
        q.delete();
        ec = 16'h0;
        #2 reset_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(b_in_ready), 64'(1));
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        repeat (4) tick();

        // random stress against the queue model
        for (int i = 0; i < 10000; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            in_sel = 5'($urandom_range(0, 23));
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        chk("stress_drained", 64'(q.size()), 64'(0));
`ifdef MUX_PIPE_ERR_COUNT_EN
        chk("stress_err_count", 64'(b_ec), 64'(ec));

        // saturation: enough out-of-range accepts to pass 16'hFFFF
        in_valid = 1'b1; in_sel = 5'd25;
        for (int i = 0; i < 65537; i++) tick();
        chk("sat_err_count", 64'(b_ec), 64'(16'hFFFF));
        repeat (3) tick();
        in_valid = 1'b0;
        repeat (3) tick();
        chk("sat_hold_err_count", 64'(b_ec), 64'(16'hFFFF));
        chk("sat_a_err_count", 64'(a_ec), 64'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
